// File: rtl/qbus_mem_ctl.sv
// Q-bus slave for the VM1 core: converts din/dout cycles into single-cycle SRAM strobes,
// with wait states, a write-protected ROM window and an unmapped hole that times out.
//  state    | meaning
//  S_IDLE   | waiting for sync_i rising edge, latches address
//  S_ADDR   | address held, waiting for din_i/dout_i
//  S_WAIT   | wait-state down-counter running
//  S_ACCESS | SRAM strobe cycle
//  S_RDATA  | SRAM read data captured into data_o
//  S_REPLY  | rply_o high until din_i/dout_i released
//  S_NORPLY | hole access: no reply, berr_o timeout pulse
module qbus_mem_ctl #(
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] ROM_BASE    = 16'o100000,
    parameter bit          ROM_WP      = 1'b1,
    parameter logic [15:0] HOLE_LO     = 16'o177000,
    parameter logic [15:0] HOLE_HI     = 16'o177577,
    parameter int          TIMEOUT     = 16
) (
    input  logic        mclk,
    input  logic        mreset,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    input  logic        sync_i,
    input  logic        din_i,
    input  logic        dout_i,
    input  logic        wtbt_i,
    output logic        rply_o,
    output logic        berr_o,
    output logic [14:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic [1:0]  mem_be_o,
    output logic        mem_rd_o,
    output logic        mem_we_o,
    input  logic [15:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_ACCESS, S_RDATA, S_REPLY, S_NORPLY
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic        r_rom;
    logic        r_hole;
    logic        r_sync_d;
    logic        r_is_rd;
    logic        r_abort;
    logic [3:0]  r_wcnt;
    logic [7:0]  r_tcnt;
    logic        r_rply;
    logic        r_berr;
    logic [15:0] r_data;
    logic        r_mem_rd;
    logic        r_mem_we;
    logic [1:0]  r_be;
    logic [15:0] r_wdata;
    logic        w_we_ok;

    assign w_we_ok = !(r_rom && ROM_WP);

    always_ff @(posedge mclk) begin
        if (mreset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_rom    <= 1'b0;
            r_hole   <= 1'b0;
            r_sync_d <= 1'b0;
            r_is_rd  <= 1'b0;
            r_abort  <= 1'b0;
            r_wcnt   <= '0;
            r_tcnt   <= '0;
            r_rply   <= 1'b0;
            r_berr   <= 1'b0;
            r_data   <= '0;
            r_mem_rd <= 1'b0;
            r_mem_we <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
        end else begin
            r_sync_d <= sync_i;
            r_mem_rd <= 1'b0;
            r_mem_we <= 1'b0;
            r_berr   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sync_i && !r_sync_d) begin
                        r_addr  <= addr_i;
                        r_rom   <= (addr_i >= ROM_BASE);
                        r_hole  <= (addr_i >= HOLE_LO) && (addr_i <= HOLE_HI);
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!sync_i) begin
                        r_state <= S_IDLE;
                    end else if (din_i || dout_i) begin
                        r_is_rd <= din_i;
                        r_abort <= 1'b0;
                        r_be    <= (!din_i && wtbt_i) ? (r_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                        if (!din_i)
                            r_wdata <= data_i;
                        if (r_hole) begin
                            r_tcnt  <= '0;
                            r_berr  <= (TIMEOUT == 1);
                            r_state <= S_NORPLY;
                        end else if (WAIT_STATES == 0) begin
                            r_mem_rd <= din_i;
                            r_mem_we <= !din_i && w_we_ok;
                            r_state  <= S_ACCESS;
                        end else begin
                            r_wcnt  <= 4'(WAIT_STATES);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A dropped frame still completes the SRAM op, only the reply is skipped.
                    if (!sync_i)
                        r_abort <= 1'b1;
                    r_wcnt <= r_wcnt - 4'd1;
                    if (r_wcnt == 4'd1) begin
                        r_mem_rd <= r_is_rd;
                        r_mem_we <= !r_is_rd && w_we_ok;
                        if (!r_is_rd && dout_i)
                            r_wdata <= data_i;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_is_rd) begin
                        r_abort <= r_abort || !sync_i;
                        r_state <= S_RDATA;
                    end else if (r_abort || !sync_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rply  <= 1'b1;
                        r_state <= S_REPLY;
                    end
                end
                S_RDATA: begin
                    r_data <= mem_rdata_i;
                    if (r_abort || !sync_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rply  <= 1'b1;
                        r_state <= S_REPLY;
                    end
                end
                S_REPLY: begin
                    if (!din_i && !dout_i) begin
                        r_rply  <= 1'b0;
                        r_state <= sync_i ? S_ADDR : S_IDLE;
                    end
                end
                S_NORPLY: begin
                    if (!sync_i) begin
                        r_state <= S_IDLE;
                    end else if (r_tcnt != 8'(TIMEOUT)) begin
                        r_tcnt <= r_tcnt + 8'd1;
                        if (r_tcnt == 8'(TIMEOUT - 2))
                            r_berr <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_o      = r_data;
    assign rply_o      = r_rply;
    assign berr_o      = r_berr;
    assign mem_addr_o  = r_addr[15:1];
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;
    assign mem_rd_o    = r_mem_rd;
    assign mem_we_o    = r_mem_we;

endmodule

// File: tb/tb_qbus_mem_ctl.sv
// Directed bench for qbus_mem_ctl with a synchronous SRAM model and strobe monitor.
module tb_qbus_mem_ctl;

    logic        mclk = 1'b0;
    logic        mreset;
    logic [15:0] addr_i, data_i, data_o;
    logic        sync_i, din_i, dout_i, wtbt_i;
    logic        rply_o, berr_o;
    logic [14:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [1:0]  mem_be_o;
    logic        mem_rd_o, mem_we_o;
    logic [15:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:32767];
    int          n_rd = 0, n_we = 0, n_both = 0;
    logic [14:0] last_rd_addr, last_we_addr;
    logic [1:0]  last_be;
    logic [15:0] last_wdata;

    qbus_mem_ctl dut (
        .mclk(mclk), .mreset(mreset), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .sync_i(sync_i), .din_i(din_i), .dout_i(dout_i), .wtbt_i(wtbt_i),
        .rply_o(rply_o), .berr_o(berr_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rd_o(mem_rd_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (mem_rd_o)
            mem_rdata_i <= mem[mem_addr_o];
        if (mem_we_o) begin
            if (mem_be_o[0]) mem[mem_addr_o][7:0]  <= mem_wdata_o[7:0];
            if (mem_be_o[1]) mem[mem_addr_o][15:8] <= mem_wdata_o[15:8];
        end
    end

    always @(negedge mclk) begin
        if (mem_rd_o) begin n_rd++; last_rd_addr = mem_addr_o; last_be = mem_be_o; end
        if (mem_we_o) begin n_we++; last_we_addr = mem_addr_o; last_be = mem_be_o; last_wdata = mem_wdata_o; end
        if (mem_rd_o && mem_we_o) n_both++;
    end

    task automatic start_frame(input logic [15:0] a);
        @(negedge mclk);
        addr_i = a;
        sync_i = 1'b1;
        @(negedge mclk);
    endtask

    task automatic end_frame();
        sync_i = 1'b0;
        repeat (2) @(negedge mclk);
    endtask

    task automatic bus_xfer(input logic rd, input logic [15:0] wd, input logic bw,
                            output int lat, output int rel, output logic [15:0] q);
        lat = -1;
        rel = -1;
        din_i  = rd;
        dout_i = !rd;
        wtbt_i = bw;
        data_i = wd;
        for (int i = 1; i <= 40; i++) begin
            @(negedge mclk);
            if (rply_o) begin lat = i; break; end
        end
        q = data_o;
        din_i  = 1'b0;
        dout_i = 1'b0;
        wtbt_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge mclk);
            if (!rply_o) begin rel = i; break; end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (rply_o !== 1'b0)       begin n_fail++; $display("FAIL reset_rply got %b want 0", rply_o); end
        n_checks++; if (berr_o !== 1'b0)       begin n_fail++; $display("FAIL reset_berr got %b want 0", berr_o); end
        n_checks++; if (data_o !== 16'h0)      begin n_fail++; $display("FAIL reset_data got %o want 0", data_o); end
        n_checks++; if (mem_rd_o !== 1'b0)     begin n_fail++; $display("FAIL reset_rd got %b want 0", mem_rd_o); end
        n_checks++; if (mem_we_o !== 1'b0)     begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we_o); end
        n_checks++; if (mem_be_o !== 2'b00)    begin n_fail++; $display("FAIL reset_be got %b want 00", mem_be_o); end
        n_checks++; if (mem_addr_o !== 15'h0)  begin n_fail++; $display("FAIL reset_addr got %o want 0", mem_addr_o); end
        n_checks++; if (mem_wdata_o !== 16'h0) begin n_fail++; $display("FAIL reset_wdata got %o want 0", mem_wdata_o); end
    endtask

    task automatic test_read();
        int lat, rel, rd0, we0;
        logic [15:0] q;
        rd0 = n_rd; we0 = n_we;
        start_frame(16'o000200);
        bus_xfer(1'b1, 16'h0, 1'b0, lat, rel, q);
        end_frame();
        n_checks++; if (lat !== 4)            begin n_fail++; $display("FAIL read_latency got %0d want 4", lat); end
        n_checks++; if (q !== 16'o012737)     begin n_fail++; $display("FAIL read_data got %o want 012737", q); end
        n_checks++; if (last_rd_addr !== 15'o100) begin n_fail++; $display("FAIL read_addr got %o want 100", last_rd_addr); end
        n_checks++; if (last_be !== 2'b11)    begin n_fail++; $display("FAIL read_be got %b want 11", last_be); end
        n_checks++; if (n_rd - rd0 !== 1)     begin n_fail++; $display("FAIL read_rd_pulses got %0d want 1", n_rd - rd0); end
        n_checks++; if (n_we - we0 !== 0)     begin n_fail++; $display("FAIL read_we_pulses got %0d want 0", n_we - we0); end
        n_checks++; if (data_o !== 16'o012737) begin n_fail++; $display("FAIL read_data_hold got %o want 012737", data_o); end
    endtask

    task automatic test_write_word();
        int lat, rel, we0;
        logic [15:0] q;
        we0 = n_we;
        start_frame(16'o000202);
        bus_xfer(1'b0, 16'o177777, 1'b0, lat, rel, q);
        end_frame();
        n_checks++; if (lat !== 3)               begin n_fail++; $display("FAIL wr_latency got %0d want 3", lat); end
        n_checks++; if (rel !== 1)               begin n_fail++; $display("FAIL wr_release got %0d want 1", rel); end
        n_checks++; if (n_we - we0 !== 1)        begin n_fail++; $display("FAIL wr_we_pulses got %0d want 1", n_we - we0); end
        n_checks++; if (last_be !== 2'b11)       begin n_fail++; $display("FAIL wr_be got %b want 11", last_be); end
        n_checks++; if (last_wdata !== 16'o177777) begin n_fail++; $display("FAIL wr_wdata got %o want 177777", last_wdata); end
        n_checks++; if (mem[15'o101] !== 16'o177777) begin n_fail++; $display("FAIL wr_mem got %o want 177777", mem[15'o101]); end
    endtask

    task automatic test_write_byte();
        int lat, rel;
        logic [15:0] q;
        start_frame(16'o000203);
        bus_xfer(1'b0, 16'o052000, 1'b1, lat, rel, q);
        end_frame();
        n_checks++; if (last_be !== 2'b10)     begin n_fail++; $display("FAIL bytehi_be got %b want 10", last_be); end
        n_checks++; if (mem[15'o101] !== 16'o052377) begin n_fail++; $display("FAIL bytehi_mem got %o want 052377", mem[15'o101]); end
        start_frame(16'o000202);
        bus_xfer(1'b0, 16'o000125, 1'b1, lat, rel, q);
        end_frame();
        n_checks++; if (last_be !== 2'b01)     begin n_fail++; $display("FAIL bytelo_be got %b want 01", last_be); end
        n_checks++; if (mem[15'o101] !== 16'o052125) begin n_fail++; $display("FAIL bytelo_mem got %o want 052125", mem[15'o101]); end
    endtask

    task automatic test_rom_wp();
        int lat, rel, we0;
        logic [15:0] q;
        we0 = n_we;
        start_frame(16'o100000);
        bus_xfer(1'b0, 16'o000777, 1'b0, lat, rel, q);
        end_frame();
        n_checks++; if (lat !== 3)         begin n_fail++; $display("FAIL rom_wr_reply got %0d want 3", lat); end
        n_checks++; if (n_we - we0 !== 0)  begin n_fail++; $display("FAIL rom_we_pulses got %0d want 0", n_we - we0); end
        start_frame(16'o100000);
        bus_xfer(1'b1, 16'h0, 1'b0, lat, rel, q);
        end_frame();
        n_checks++; if (lat !== 4)          begin n_fail++; $display("FAIL rom_rd_latency got %0d want 4", lat); end
        n_checks++; if (q !== 16'o123456)   begin n_fail++; $display("FAIL rom_rd_data got %o want 123456", q); end
    endtask

    task automatic test_hole();
        int berr_at, berr_cnt, rply_cnt, rd0, we0, lat, rel;
        logic [15:0] q;
        rd0 = n_rd; we0 = n_we;
        berr_at = -1; berr_cnt = 0; rply_cnt = 0;
        start_frame(16'o177100);
        din_i = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge mclk);
            if (berr_o) begin berr_cnt++; if (berr_at < 0) berr_at = i; end
            if (rply_o) rply_cnt++;
        end
        din_i = 1'b0;
        end_frame();
        n_checks++; if (berr_at !== 16)   begin n_fail++; $display("FAIL hole_berr_time got %0d want 16", berr_at); end
        n_checks++; if (berr_cnt !== 1)   begin n_fail++; $display("FAIL hole_berr_width got %0d want 1", berr_cnt); end
        n_checks++; if (rply_cnt !== 0)   begin n_fail++; $display("FAIL hole_rply got %0d want 0", rply_cnt); end
        n_checks++; if ((n_rd - rd0) + (n_we - we0) !== 0) begin n_fail++; $display("FAIL hole_strobes got %0d want 0", (n_rd - rd0) + (n_we - we0)); end
        start_frame(16'o000200);
        bus_xfer(1'b1, 16'h0, 1'b0, lat, rel, q);
        end_frame();
        n_checks++; if (q !== 16'o012737) begin n_fail++; $display("FAIL hole_recover_data got %o want 012737", q); end
    endtask

    task automatic test_datio();
        int lat_r, lat_w, rel, rd0, we0;
        logic [15:0] q, qw;
        rd0 = n_rd; we0 = n_we;
        start_frame(16'o000300);
        bus_xfer(1'b1, 16'h0, 1'b0, lat_r, rel, q);
        bus_xfer(1'b0, 16'o000001, 1'b0, lat_w, rel, qw);
        end_frame();
        n_checks++; if (lat_r !== 4)          begin n_fail++; $display("FAIL datio_rd_reply got %0d want 4", lat_r); end
        n_checks++; if (lat_w !== 3)          begin n_fail++; $display("FAIL datio_wr_reply got %0d want 3", lat_w); end
        n_checks++; if (q !== 16'o070707)     begin n_fail++; $display("FAIL datio_rd_data got %o want 070707", q); end
        n_checks++; if (n_rd - rd0 !== 1)     begin n_fail++; $display("FAIL datio_rd_pulses got %0d want 1", n_rd - rd0); end
        n_checks++; if (n_we - we0 !== 1)     begin n_fail++; $display("FAIL datio_we_pulses got %0d want 1", n_we - we0); end
        n_checks++; if (last_rd_addr !== 15'o140) begin n_fail++; $display("FAIL datio_rd_addr got %o want 140", last_rd_addr); end
        n_checks++; if (last_we_addr !== 15'o140) begin n_fail++; $display("FAIL datio_we_addr got %o want 140", last_we_addr); end
        n_checks++; if (mem[15'o140] !== 16'o000001) begin n_fail++; $display("FAIL datio_mem got %o want 000001", mem[15'o140]); end
    endtask

    task automatic test_reset_mid();
        int rd0, we0, lat, rel;
        logic [15:0] q;
        rd0 = n_rd; we0 = n_we;
        start_frame(16'o000200);
        din_i = 1'b1;
        @(negedge mclk);
        mreset = 1'b1;
        din_i  = 1'b0;
        sync_i = 1'b0;
        @(negedge mclk);
        n_checks++; if (rply_o !== 1'b0)   begin n_fail++; $display("FAIL midrst_rply got %b want 0", rply_o); end
        n_checks++; if (mem_rd_o !== 1'b0) begin n_fail++; $display("FAIL midrst_rd got %b want 0", mem_rd_o); end
        n_checks++; if (data_o !== 16'h0)  begin n_fail++; $display("FAIL midrst_data got %o want 0", data_o); end
        mreset = 1'b0;
        repeat (5) @(negedge mclk);
        n_checks++; if ((n_rd - rd0) + (n_we - we0) !== 0) begin n_fail++; $display("FAIL midrst_strobes got %0d want 0", (n_rd - rd0) + (n_we - we0)); end
        start_frame(16'o000200);
        bus_xfer(1'b1, 16'h0, 1'b0, lat, rel, q);
        end_frame();
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL midrst_recover got %0d want 4", lat); end
    endtask

    initial begin
        mreset = 1'b1;
        addr_i = '0; data_i = '0;
        sync_i = 1'b0; din_i = 1'b0; dout_i = 1'b0; wtbt_i = 1'b0;
        mem[15'o100]   <= 16'o012737;
        mem[15'o40000] <= 16'o123456;
        mem[15'o140]   <= 16'o070707;
        repeat (3) @(negedge mclk);
        test_reset();
        mreset = 1'b0;
        @(negedge mclk);
        test_read();
        test_write_word();
        test_write_byte();
        test_rom_wp();
        test_hole();
        test_datio();
        test_reset_mid();
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL rd_we_overlap got %0d want 0", n_both); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
